// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - byte-stream image loader: length-prefixed words to RAM, then checksum read-back verify
`ifndef RAM_DEPTH
`define RAM_DEPTH 1024
`endif

module ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = `RAM_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        ram_wen_o,
  output logic [31:0] ram_waddr_o,
  output logic [31:0] ram_wdata_o,
  output logic [31:0] ram_raddr_o,
  input  logic [31:0] ram_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [31:0] words_o
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, VERIFY, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]  byte_cnt;
  logic [31:0] len_q, word_q, idx_q, csum_q, rsum_q, words_q, len_full;
  logic [1:0]  err_q;

  assign err_o   = err_q;
  assign words_o = words_q;

  // Length as it will stand once the 4th (most significant) byte lands
  always_comb begin
    len_full        = len_q;
    len_full[31:24] = byte_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    byte_ready_o = 1'b0;
    ram_wen_o    = 1'b0;
    ram_waddr_o  = '0;
    ram_wdata_o  = '0;
    ram_raddr_o  = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = LEN;
      LEN: begin
        busy_o       = 1'b1;
        byte_ready_o = 1'b1;
        if (byte_valid_i && byte_cnt == 2'd3)
          state_nx = (len_full == '0 || len_full > MAX_W) ? DONE : DATA;
      end
      DATA: begin
        busy_o       = 1'b1;
        byte_ready_o = 1'b1;
        if (byte_valid_i && byte_cnt == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        busy_o      = 1'b1;
        ram_wen_o   = 1'b1;
        ram_waddr_o = BASE_ADDR + (idx_q << 2);
        ram_wdata_o = word_q;
        state_nx    = (idx_q + 32'd1 < len_q) ? DATA : VERIFY;
      end
      VERIFY: begin
        busy_o = 1'b1;
        if (idx_q < len_q) ram_raddr_o = BASE_ADDR + (idx_q << 2);
        if (idx_q == len_q) state_nx = DONE;
      end
      DONE: begin
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt <= '0;
      len_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      rsum_q   <= '0;
      words_q  <= '0;
      err_q    <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          byte_cnt <= '0;
          len_q    <= '0;
          idx_q    <= '0;
          csum_q   <= '0;
          rsum_q   <= '0;
          words_q  <= '0;
          err_q    <= '0;
        end
        LEN: if (byte_valid_i) begin
          len_q[{byte_cnt, 3'b000} +: 8] <= byte_data_i;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3 && len_full > MAX_W) err_q <= 2'b01;
        end
        DATA: if (byte_valid_i) begin
          word_q[{byte_cnt, 3'b000} +: 8] <= byte_data_i;
          byte_cnt <= byte_cnt + 2'd1;
        end
        WRITE: begin
          csum_q  <= csum_q + word_q;
          words_q <= words_q + 32'd1;
          idx_q   <= (idx_q + 32'd1 < len_q) ? idx_q + 32'd1 : '0;
        end
        VERIFY: begin
          // Read data lags the address by one cycle, so cycle 0 has nothing to add
          if (idx_q != '0) rsum_q <= rsum_q + ram_rdata_i;
          idx_q <= idx_q + 32'd1;
          if (idx_q == len_q)
            err_q <= ((rsum_q + ram_rdata_i) != csum_q) ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader
module tb_ram_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int MAXW = 8;

  logic clk = 1'b0;
  logic rst_i, start_i, byte_valid_i, byte_ready_o, ram_wen_o, busy_o, done_o;
  logic [7:0] byte_data_i;
  logic [31:0] ram_waddr_o, ram_wdata_o, ram_raddr_o, ram_rdata_i, words_o;
  logic [1:0] err_o;

  always #5 clk = ~clk;

  ram_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .ram_wen_o(ram_wen_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
    .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural RAM: synchronous write, one-cycle read latency, optional corrupted word on read
  logic [31:0] mem [0:15];
  logic [31:0] img [0:15];
  int corrupt_idx = -1;
  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'd15);
  endfunction
  always @(posedge clk) begin
    if (ram_wen_o) mem[widx(ram_waddr_o)] <= ram_wdata_o;
    ram_rdata_i <= (widx(ram_raddr_o) == corrupt_idx) ? (mem[widx(ram_raddr_o)] ^ 32'h1)
                                                      : mem[widx(ram_raddr_o)];
  end

  logic [31:0] wa_q[$], wd_q[$], ra_q[$];
  int viol = 0;
  always @(negedge clk) begin
    if (ram_wen_o) begin wa_q.push_back(ram_waddr_o); wd_q.push_back(ram_wdata_o); end
    if (busy_o && !byte_ready_o && !ram_wen_o) ra_q.push_back(ram_raddr_o);
    if ((ram_wen_o && byte_ready_o) || (!ram_wen_o && (ram_waddr_o != 0 || ram_wdata_o != 0)) ||
        (ram_wen_o && !busy_o) || (done_o && busy_o) || (byte_ready_o && !busy_o) ||
        (ram_raddr_o != 0 && !(busy_o && !byte_ready_o && !ram_wen_o)))
      viol++;
  end

  function automatic logic [1:0] model_err(input logic [31:0] n, input int corrupt);
    if (n > 32'(MAXW)) return 2'b01;
    if (n != 0 && corrupt >= 0 && corrupt < int'(n)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic do_case(input string tag, input logic [31:0] n, input bit rnd, input int corrupt,
                         input logic [1:0] exp_err, input logic [31:0] exp_words);
    logic [7:0] bq[$];
    int nsend, cyc, last_x, lat, got, stalls, bad;
    bit seen, ok_len;
    ok_len = (n != 0) && (n <= 32'(MAXW));
    nsend  = ok_len ? int'(n) : 0;
    for (int b = 0; b < 4; b++) bq.push_back(n[8*b +: 8]);
    for (int w = 0; w < nsend; w++)
      for (int b = 0; b < 4; b++) bq.push_back(img[w][8*b +: 8]);
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    corrupt_idx = corrupt;
    @(negedge clk); start_i = 1'b1;
    cyc = 0; last_x = 0; lat = -1; got = 0; stalls = 0; seen = 1'b0;
    while (cyc < 500 && !seen) begin
      @(negedge clk); start_i = 1'b0;
      if (done_o) begin
        seen = 1'b1;
        lat  = cyc - last_x;
        check({tag, "_err"}, err_o, exp_err);
        check({tag, "_words"}, words_o, exp_words);
      end else begin
        if (bq.size() > 0) begin
          byte_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          byte_data_i  = bq[0];
          if (!byte_ready_o) stalls++;
          if (byte_valid_i && byte_ready_o) begin void'(bq.pop_front()); got++; last_x = cyc; end
        end else byte_valid_i = 1'b0;
        cyc++;
      end
    end
    byte_valid_i = 1'b0;
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, 64'(lat), ok_len ? 64'(n + 3) : 64'd1);
    check({tag, "_bytes"}, 64'(got), 64'(4 + 4 * nsend));
    check({tag, "_nwrites"}, wa_q.size(), 64'(nsend));
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 16; i++)
      if (wa_q[i] !== BASE + 32'(4 * i) || wd_q[i] !== img[i]) bad++;
    check({tag, "_write_contents"}, 64'(bad), 0);
    check({tag, "_verify_cycles"}, ra_q.size(), ok_len ? 64'(n + 1) : 64'd0);
    bad = 0;
    for (int k = 0; k < nsend && k < ra_q.size(); k++)
      if (ra_q[k] !== BASE + 32'(4 * k)) bad++;
    check({tag, "_verify_addrs"}, 64'(bad), 0);
    if (!rnd) check({tag, "_ready_drops"}, 64'(stalls), ok_len ? 64'(n - 1) : 64'd0);
    @(negedge clk);
    check({tag, "_after_done"}, {done_o, byte_ready_o, busy_o}, 3'b000);
    check({tag, "_err_held"}, err_o, exp_err);
    check({tag, "_words_held"}, words_o, exp_words);
    corrupt_idx = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("send_byte_timeout", 64'(t), 0);
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] n;
    bit          rnd;
    int          corrupt;
    logic [1:0]  exp_err;
    logic [31:0] exp_words;
    bit          fixed;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [31:0] n;
    int c;
    bit r;
    rst_i = 1'b1; start_i = 1'b1; byte_valid_i = 1'b0; byte_data_i = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", |{byte_ready_o, ram_wen_o, ram_waddr_o, ram_wdata_o, ram_raddr_o,
                             busy_o, done_o, err_o, words_o}, 1'b0);
    rst_i = 1'b0; start_i = 1'b0;

    tbl[0] = '{32'd4,         1'b0, -1, 2'b00, 32'd4, 1'b1};
    tbl[1] = '{32'd0,         1'b0, -1, 2'b00, 32'd0, 1'b0};
    tbl[2] = '{32'd9,         1'b0, -1, 2'b01, 32'd0, 1'b0};
    tbl[3] = '{32'd8,         1'b1, -1, 2'b00, 32'd8, 1'b0};
    tbl[4] = '{32'd1,         1'b0, -1, 2'b00, 32'd1, 1'b0};
    tbl[5] = '{32'd3,         1'b0,  1, 2'b10, 32'd3, 1'b0};
    tbl[6] = '{32'd5,         1'b1, -1, 2'b00, 32'd5, 1'b0};
    tbl[7] = '{32'hFFFF_FFFF, 1'b0, -1, 2'b01, 32'd0, 1'b0};
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      if (tbl[t].fixed) begin img[0] = 32'h0000_0001; img[1] = 32'hDEAD_BEEF; end
      do_case($sformatf("vec%0d", t), tbl[t].n, tbl[t].rnd, tbl[t].corrupt,
              tbl[t].exp_err, tbl[t].exp_words);
    end

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      n = 32'($urandom_range(0, 10));
      r = 1'($urandom_range(0, 1));
      c = (n != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, int'(n) - 1) : -1;
      do_case($sformatf("rnd%0d", t), n, r, c, model_err(n, c), (n <= 32'(MAXW)) ? n : 32'd0);
    end

    // Start during DONE is dropped; the following start in IDLE clears err
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    send_byte(8'h09); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("seqA_done", done_o, 1'b1);
    check("seqA_err", err_o, 2'b01);
    start_i = 1'b1;
    @(negedge clk);
    check("seqA_start_in_done_ignored", busy_o, 1'b0);
    check("seqA_err_kept", err_o, 2'b01);
    @(negedge clk); start_i = 1'b0;
    check("seqA_start_accepted", busy_o, 1'b1);
    check("seqA_err_cleared", err_o, 2'b00);

    // Stall in DATA, then reset after the 2nd write
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    repeat (30) @(negedge clk);
    check("seqB_stall_busy_ready", {busy_o, byte_ready_o}, 2'b11);
    check("seqB_stall_nwrites", wa_q.size(), 1);
    check("seqB_word0", (wd_q.size() > 0) ? wd_q[0] : 32'hx, 32'h1122_3344);
    send_byte(8'h88); send_byte(8'h77); send_byte(8'h66); send_byte(8'h55);
    @(negedge clk);
    check("seqB_words_before_reset", words_o, 32'd2);
    rst_i = 1'b1; byte_valid_i = 1'b1; byte_data_i = 8'hAA;
    @(negedge clk);
    check("seqB_reset_outputs", |{byte_ready_o, ram_wen_o, ram_waddr_o, ram_wdata_o, ram_raddr_o,
                                  busy_o, done_o, err_o, words_o}, 1'b0);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);
    byte_valid_i = 1'b0;
    check("seqB_no_writes_after_reset", wa_q.size(), 2);
    check("seqB_idle_after_reset", busy_o, 1'b0);
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    do_case("post_reset", 32'd1, 1'b0, -1, 2'b00, 32'd1);

    check("output_invariants", 64'(viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
